// File: rtl/nasti_bram_ctrl.sv
// nasti_bram_ctrl
// ---------------
// Bridges a NASTI (AXI4-style) slave port onto a single 64-bit-wide block
// RAM.  Only one transaction is handled at a time.  Writes go straight to
// the RAM as each W beat is accepted.  Reads take three cycles per beat:
// address, RAM latency, then hold the beat until the master takes it.
//
// Ports
//   clk, rst              : single clock, synchronous active-high reset
//   aw_* / w_* / b_*      : write address, write data and write response channels
//   ar_* / r_*            : read address and read data channels
//   ram_en, ram_we        : RAM enable and per-byte write enables
//   ram_addr              : RAM byte address, always 8-byte aligned
//   ram_wrdata            : RAM write data
//   ram_rddata            : RAM read data, valid one cycle after a read enable
module nasti_bram_ctrl #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_AW     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // write address channel
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic [ID_WIDTH-1:0]   aw_id,
  input  logic [ADDR_WIDTH-1:0] aw_addr,
  input  logic [7:0]            aw_len,
  input  logic [1:0]            aw_burst,
  // write data channel
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [63:0]           w_data,
  input  logic [7:0]            w_strb,
  input  logic                  w_last,
  // write response channel
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic [ID_WIDTH-1:0]   b_id,
  output logic [1:0]            b_resp,
  // read address channel
  input  logic                  ar_valid,
  output logic                  ar_ready,
  input  logic [ID_WIDTH-1:0]   ar_id,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic [7:0]            ar_len,
  input  logic [1:0]            ar_burst,
  // read data channel
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [ID_WIDTH-1:0]   r_id,
  output logic [63:0]           r_data,
  output logic [1:0]            r_resp,
  output logic                  r_last,
  // block RAM port
  output logic                  ram_en,
  output logic [7:0]            ram_we,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [63:0]           ram_wrdata,
  input  logic [63:0]           ram_rddata
);

  localparam int IDX_W = RAM_AW - 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WRESP,
    RD_ADDR,
    RD_WAIT,
    RD_SEND
  } state_t;

  state_t              state_q, state_d;
  logic                prio_wr_q, prio_wr_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          len_q, len_d;
  logic [1:0]          burst_q, burst_d;
  logic [7:0]          beat_q, beat_d;
  logic                err_q, err_d;
  logic [63:0]         r_data_q, r_data_d;

  logic                grant_wr;
  logic                grant_rd;
  logic                bad_burst;
  logic                last_beat;
  logic [IDX_W-1:0]    idx_next;

  // The byte offset and anything above the RAM window play no part in
  // addressing; folding them here keeps them visibly consumed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{aw_addr[ADDR_WIDTH-1:RAM_AW], aw_addr[2:0],
                              ar_addr[ADDR_WIDTH-1:RAM_AW], ar_addr[2:0]};

  assign r_data = r_data_q;

  // Burst types 2'b10/2'b11 are unsupported: the beats still flow but the
  // RAM is never written and reads return zero.  FIXED holds the index.
  assign bad_burst = burst_q[1];
  assign last_beat = (beat_q == len_q);
  assign idx_next  = (burst_q == BURST_INCR) ? idx_q + IDX_W'(1) : idx_q;

  // Next-state and output logic for the single-transaction FSM.
  always_comb begin
    state_d    = state_q;
    prio_wr_d  = prio_wr_q;
    id_d       = id_q;
    idx_d      = idx_q;
    len_d      = len_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    err_d      = err_q;
    r_data_d   = r_data_q;

    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    aw_ready   = 1'b0;
    ar_ready   = 1'b0;
    w_ready    = 1'b0;
    b_valid    = 1'b0;
    b_id       = id_q;
    b_resp     = err_q ? RESP_SLVERR : RESP_OKAY;
    r_valid    = 1'b0;
    r_id       = id_q;
    r_resp     = err_q ? RESP_SLVERR : RESP_OKAY;
    r_last     = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 8'h00;
    ram_addr   = {idx_q, 3'b000};
    ram_wrdata = w_data;

    case (state_q)
      IDLE: begin
        // A lone request is always granted; a contested one goes to the
        // channel holding priority, which then passes to the other side.
        grant_wr = aw_valid && (!ar_valid || prio_wr_q);
        grant_rd = ar_valid && !grant_wr;
        aw_ready = grant_wr;
        ar_ready = grant_rd;
        if (grant_wr) begin
          id_d      = aw_id;
          idx_d     = aw_addr[RAM_AW-1:3];
          len_d     = aw_len;
          burst_d   = aw_burst;
          beat_d    = 8'd0;
          // error flag starts cleared, except that a bad burst type is
          // already known to be an error
          err_d     = aw_burst[1];
          prio_wr_d = 1'b0;
          state_d   = WR;
        end else if (grant_rd) begin
          id_d      = ar_id;
          idx_d     = ar_addr[RAM_AW-1:3];
          len_d     = ar_len;
          burst_d   = ar_burst;
          beat_d    = 8'd0;
          err_d     = ar_burst[1];
          prio_wr_d = 1'b1;
          state_d   = RD_ADDR;
        end
      end

      WR: begin
        w_ready = 1'b1;
        if (w_valid) begin
          ram_en = 1'b1;
          ram_we = bad_burst ? 8'h00 : w_strb;
          // a misplaced w_last is flagged but never shortens or extends
          // the burst; len alone decides when it ends
          if (w_last != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = WRESP;
          end else begin
            beat_d = beat_q + 8'd1;
            idx_d  = idx_next;
          end
        end
      end

      WRESP: begin
        b_valid = 1'b1;
        if (b_ready) begin
          state_d = IDLE;
        end
      end

      RD_ADDR: begin
        ram_en  = 1'b1;
        state_d = RD_WAIT;
      end

      RD_WAIT: begin
        r_data_d = bad_burst ? 64'd0 : ram_rddata;
        state_d  = RD_SEND;
      end

      RD_SEND: begin
        r_valid = 1'b1;
        r_last  = last_beat;
        if (r_ready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            idx_d   = idx_next;
            state_d = RD_ADDR;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prio_wr_q <= 1'b1;
      id_q      <= '0;
      idx_q     <= '0;
      len_q     <= 8'd0;
      burst_q   <= 2'b00;
      beat_q    <= 8'd0;
      err_q     <= 1'b0;
      r_data_q  <= 64'd0;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      id_q      <= id_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      r_data_q  <= r_data_d;
    end
  end

endmodule

// File: doc/nasti_bram_ctrl.md
NASTI_BRAM_CTRL -- requirements
Module: nasti_bram_ctrl
Interface
REQ-001 ID_WIDTH, default 4, width of all NASTI id fields.
REQ-002 ADDR_WIDTH, default 32, NASTI physical address width.
REQ-003 RAM_AW, default 16, BRAM byte-address width; depth is 2^(RAM_AW-3) 64-bit words.
REQ-004 clk  in  1  the block's only clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 aw_valid  in  1  write address valid.
REQ-007 aw_ready  out  1  write address accepted.
REQ-008 aw_id  in  ID_WIDTH  write transaction id.
REQ-009 aw_addr  in  ADDR_WIDTH  write start byte address.
REQ-010 aw_len  in  8  write beats minus one.
REQ-011 aw_burst  in  2  write burst type.
REQ-012 w_valid  in  1  write data valid.
REQ-013 w_ready  out  1  write data accepted.
REQ-014 w_data  in  64  write data.
REQ-015 w_strb  in  8  byte enables.
REQ-016 w_last  in  1  final write beat marker.
REQ-017 b_valid  out  1  write response valid.
REQ-018 b_ready  in  1  write response accepted.
REQ-019 b_id  out  ID_WIDTH  write response id.
REQ-020 b_resp  out  2  write response code.
REQ-021 ar_valid  in  1  read address valid.
REQ-022 ar_ready  out  1  read address accepted.
REQ-023 ar_id  in  ID_WIDTH  read transaction id.
REQ-024 ar_addr  in  ADDR_WIDTH  read start byte address.
REQ-025 ar_len  in  8  read beats minus one.
REQ-026 ar_burst  in  2  read burst type.
REQ-027 r_valid  out  1  read data valid.
REQ-028 r_ready  in  1  read data accepted.
REQ-029 r_id  out  ID_WIDTH  read data id.
REQ-030 r_data  out  64  read data.
REQ-031 r_resp  out  2  read response code.
REQ-032 r_last  out  1  final read beat marker.
REQ-033 ram_en  out  1  BRAM access enable.
REQ-034 ram_we  out  8  BRAM byte write enables.
REQ-035 ram_addr  out  RAM_AW  BRAM byte address, word-aligned (bits [2:0] = 0).
REQ-036 ram_wrdata  out  64  BRAM write data.
REQ-037 ram_rddata  in  64  BRAM read data, valid the cycle after ram_en with ram_we=0.
Function
REQ-038 The FSM SHALL have states IDLE, WR, WRESP, RD_ADDR, RD_WAIT, RD_SEND, with one transaction in flight.
- aw_ready/ar_ready high only in IDLE, only for the granted channel.
- If both are valid in IDLE, grant alternates, write first after reset.
- The handshake latches id, word index, len and burst, clears the beat counter and error flag, and moves to WR or RD_ADDR.
REQ-039 Write path:
- WR holds w_ready=1.
- Each w handshake drives, in the same cycle, ram_en=1, ram_we=w_strb, ram_addr=index<<3, ram_wrdata=w_data.
- After beat len+1 the FSM goes to WRESP, which holds b_valid with the latched id until b_ready, then returns to IDLE.
REQ-040 Read path:
- RD_ADDR drives ram_en=1, ram_we=0 for one cycle.
- RD_WAIT registers ram_rddata into r_data.
- RD_SEND holds r_valid, r_data, r_id and r_last=(beat==len) stable until r_ready, then goes to RD_ADDR (more beats) or IDLE.
- Throughput is one beat per three cycles minimum.
REQ-041 Addressing:
- Word index = addr[RAM_AW-1:3]; bits above RAM_AW and addr[2:0] are ignored.
- INCR (2'b01) adds 1 per beat, wrapping modulo 2^(RAM_AW-3).
- FIXED (2'b00) holds the index.
REQ-042 burst 2'b10/2'b11 SHALL give SLVERR (2'b10) on b or every r beat; all beats are still exchanged, with ram_we=0 and r_data=0.
REQ-043 A w_last not equal to (beat==len) on any beat SHALL set SLVERR; the write itself is still performed, and the beat count is governed solely by len.
REQ-044 Otherwise resp SHALL be OKAY (2'b00); ram_en=0 and ram_we=0 in every cycle not listed above.
Reset
REQ-045 rst sampled high SHALL force:
- IDLE state; all valid/ready, ram_en, ram_we, r_data and r_last to 0; grant priority to write.
- Any in-flight transaction is abandoned with no response.
- rst overrides any handshake in the same cycle.
Verification
REQ-046 Write aw_addr=0x80, len=0, INCR, w_data=0x1122334455667788, strb=0xFF, last=1 -> one cycle ram_addr=0x0080, ram_we=0xFF; b_resp=OKAY, b_id echoed.
REQ-047 Read addr=0xFFE8, len=3, INCR, RAM_AW=16 -> ram_addr 0xFFE8, 0xFFF0, 0xFFF8, 0x0000; r_last only on beat 4; r_ready low 5 cycles keeps r_data stable.
REQ-048 aw_valid and ar_valid together after reset -> write served first; next simultaneous request -> read served first.
REQ-049 Error cases:
- burst=2'b11 len=1 write -> no ram_we, b_resp=SLVERR.
- w_last=1 on beat 0 of len=1 -> SLVERR.
- rst during RD_SEND -> r_valid=0 next cycle, no further beats.
